asteroid_spawner: RTL and testbench

Upstream controller for the bank of asteroid units. It owns the pool of N_AST asteroid slots, launches waves of large asteroids, and turns accepted hits into stop pulses plus split-children spawns. It drives the per-unit `new_asteroid`/`asteroid_hit` strobes and the shared spawn-parameter bus. Every unit's `ast_type`, `asteroid_x_init`, `asteroid_y_init`, `phase_n` and `phase_inc_n` inputs connect to this bus.

---
 rtl/asteroids_pkg.sv | 26 ++
 rtl/asteroid_spawner_lfsr.sv | 21 ++
 rtl/asteroid_spawner.sv | 252 +++++++++++++++++++++++++
 tb/tb_asteroid_spawner.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// Shared types and constants for the asteroid field controller.
// Asteroid sizes, spawner FSM states, score values and LFSR feedback taps.
package asteroids;

    typedef enum logic [1:0] {
        AST_LARGE = 2'd0,
        AST_MED   = 2'd1,
        AST_SMALL = 2'd2
    } ast_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAVE,
        S_RUN,
        S_SPLIT_A,
        S_SPLIT_B
    } spawn_state_t;

    localparam logic [6:0] PTS_LARGE = 7'd20;
    localparam logic [6:0] PTS_MED   = 7'd50;
    localparam logic [6:0] PTS_SMALL = 7'd100;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/asteroid_spawner_lfsr.sv
// 16-bit Galois LFSR used as the spawn-randomness source.
// Free-running; reset loads SEED, which must be nonzero.
module ast_lfsr
    import asteroids::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/asteroid_spawner.sv
// Owns the asteroid slot pool: launches waves of large asteroids and turns
// accepted hits into stop strobes, score pulses and split-children spawns.
module asteroid_spawner
    import asteroids::*;
#(
    parameter int          N_AST     = 8,
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter int          WAVE_BASE = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start_done,
    input  logic                                    wave_start,
    input  logic                                    hit_valid,
    input  logic [$clog2(N_AST)-1:0]                hit_idx,
    output logic                                    hit_ready,
    input  logic [N_AST-1:0][$clog2(WIDTH)-1:0]     ast_x,
    input  logic [N_AST-1:0][$clog2(HEIGHT)-1:0]    ast_y,
    output logic [N_AST-1:0]                        new_asteroid,
    output logic [N_AST-1:0]                        asteroid_hit,
    output ast_t [N_AST-1:0]                        ast_type,
    output logic [$clog2(WIDTH)-1:0]                x_init,
    output logic [$clog2(HEIGHT)-1:0]               y_init,
    output logic [9:0]                              phase_n,
    output logic [3:0]                              phase_inc_n,
    output logic [N_AST-1:0]                        active,
    output logic                                    score_valid,
    output logic [6:0]                              score_pts,
    output logic                                    wave_clear,
    output logic [3:0]                              wave_num
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = $clog2(N_AST);
    localparam int CW = $clog2(N_AST + 1);

    spawn_state_t state, state_next;
    logic [15:0]  lfsr;

    logic [CW-1:0] cnt, cnt_d, wave_len;
    logic [XW-1:0] hx, hx_d;
    logic [YW-1:0] hy, hy_d;
    ast_t          ptype, ptype_d;
    logic [9:0]    phase_p, phase_p_d;

    logic [N_AST-1:0] new_d, hit_d, active_d;
    ast_t [N_AST-1:0] type_d;
    logic [XW-1:0]    x_d;
    logic [YW-1:0]    y_d;
    logic [9:0]       phase_d;
    logic [3:0]       inc_d;
    logic             score_valid_d, wave_clear_d, hit_ready_d;
    logic [6:0]       score_pts_d;
    logic [3:0]       wave_num_d;

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          wave_go, hit_accept;

    logic          spawn_en;
    ast_t          spawn_type;
    logic [XW-1:0] spawn_x, edge_x;
    logic [YW-1:0] spawn_y, edge_y;
    logic [9:0]    spawn_phase;
    int unsigned   raw_x, raw_y, wl;

    ast_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < N_AST; i++) begin
            if (!active[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // Wave spawns enter on the left or top edge, folded back onto the screen.
    always_comb begin
        raw_x = {22'd0, lfsr[9:0]};
        raw_y = {23'd0, lfsr[8:0]};
        if (raw_x >= unsigned'(WIDTH))  raw_x = raw_x - unsigned'(WIDTH);
        if (raw_y >= unsigned'(HEIGHT)) raw_y = raw_y - unsigned'(HEIGHT);
        edge_x = lfsr[15] ? XW'(raw_x) : '0;
        edge_y = lfsr[15] ? '0 : YW'(raw_y);
    end

    always_comb begin
        wl = unsigned'(WAVE_BASE) + 32'(wave_num) * 2;
        if (wl > unsigned'(N_AST)) wl = unsigned'(N_AST);
        wave_len = CW'(wl);
    end

    assign wave_go    = wave_start & (start_done | (wave_num != '0));
    assign hit_accept = (state == S_RUN) & hit_valid & hit_ready & active[hit_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            hx           <= '0;
            hy           <= '0;
            ptype        <= AST_LARGE;
            phase_p      <= '0;
            new_asteroid <= '0;
            asteroid_hit <= '0;
            for (int unsigned i = 0; i < N_AST; i++) ast_type[i] <= AST_LARGE;
            x_init       <= '0;
            y_init       <= '0;
            phase_n      <= '0;
            phase_inc_n  <= '0;
            active       <= '0;
            score_valid  <= 1'b0;
            score_pts    <= '0;
            wave_clear   <= 1'b0;
            wave_num     <= '0;
            hit_ready    <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_d;
            hx           <= hx_d;
            hy           <= hy_d;
            ptype        <= ptype_d;
            phase_p      <= phase_p_d;
            new_asteroid <= new_d;
            asteroid_hit <= hit_d;
            ast_type     <= type_d;
            x_init       <= x_d;
            y_init       <= y_d;
            phase_n      <= phase_d;
            phase_inc_n  <= inc_d;
            active       <= active_d;
            score_valid  <= score_valid_d;
            score_pts    <= score_pts_d;
            wave_clear   <= wave_clear_d;
            wave_num     <= wave_num_d;
            hit_ready    <= hit_ready_d;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (wave_go) state_next = (wave_len == CW'(1)) ? S_RUN : S_WAVE;
            S_WAVE:    if (cnt == CW'(1)) state_next = S_RUN;
            S_RUN: begin
                if (hit_accept)
                    state_next = (ast_type[hit_idx] == AST_SMALL) ? S_RUN : S_SPLIT_A;
                else if (active == '0)
                    state_next = S_IDLE;
            end
            S_SPLIT_A: state_next = S_SPLIT_B;
            S_SPLIT_B: state_next = S_RUN;
            default:   state_next = S_IDLE;
        endcase
    end

    // The first wave spawn is issued on the IDLE exit edge so its strobe lands
    // one cycle after wave_start; cnt then tracks spawns still owed.
    always_comb begin
        cnt_d         = cnt;
        hx_d          = hx;
        hy_d          = hy;
        ptype_d       = ptype;
        phase_p_d     = phase_p;
        new_d         = '0;
        hit_d         = '0;
        active_d      = active;
        type_d        = ast_type;
        x_d           = x_init;
        y_d           = y_init;
        phase_d       = phase_n;
        inc_d         = phase_inc_n;
        score_valid_d = 1'b0;
        score_pts_d   = score_pts;
        wave_clear_d  = 1'b0;
        wave_num_d    = wave_num;
        spawn_en      = 1'b0;
        spawn_type    = AST_LARGE;
        spawn_x       = edge_x;
        spawn_y       = edge_y;
        spawn_phase   = lfsr[9:0];

        unique case (state)
            S_IDLE: begin
                if (wave_go) begin
                    spawn_en = 1'b1;
                    cnt_d    = wave_len - CW'(1);
                end
            end
            S_WAVE: begin
                spawn_en = 1'b1;
                cnt_d    = cnt - CW'(1);
            end
            S_RUN: begin
                if (hit_accept) begin
                    hx_d             = ast_x[hit_idx];
                    hy_d             = ast_y[hit_idx];
                    ptype_d          = ast_type[hit_idx];
                    hit_d[hit_idx]   = 1'b1;
                    active_d[hit_idx] = 1'b0;
                    score_valid_d    = 1'b1;
                    unique case (ast_type[hit_idx])
                        AST_LARGE: score_pts_d = PTS_LARGE;
                        AST_MED:   score_pts_d = PTS_MED;
                        default:   score_pts_d = PTS_SMALL;
                    endcase
                end else if (active == '0) begin
                    wave_clear_d = 1'b1;
                    if (wave_num != 4'd15) wave_num_d = wave_num + 4'd1;
                end
            end
            S_SPLIT_A: begin
                spawn_en   = 1'b1;
                spawn_type = (ptype == AST_LARGE) ? AST_MED : AST_SMALL;
                spawn_x    = hx;
                spawn_y    = hy;
                phase_p_d  = lfsr[9:0];
            end
            S_SPLIT_B: begin
                spawn_en    = 1'b1;
                spawn_type  = (ptype == AST_LARGE) ? AST_MED : AST_SMALL;
                spawn_x     = hx;
                spawn_y     = hy;
                spawn_phase = phase_p + 10'd512;
            end
            default: ;
        endcase

        if (spawn_en && free_found) begin
            new_d[free_idx]    = 1'b1;
            active_d[free_idx] = 1'b1;
            type_d[free_idx]   = spawn_type;
            x_d                = spawn_x;
            y_d                = spawn_y;
            phase_d            = spawn_phase;
            inc_d              = 4'(lfsr >> 10);
        end

        hit_ready_d = (state == S_RUN) && (state_next == S_RUN) && !hit_accept;
    end

endmodule

// File: tb/tb_asteroid_spawner.sv
// Directed self-checking bench for asteroid_spawner with default parameters.
// An independent LFSR model supplies the expected spawn positions and headings.
module tb_asteroid_spawner;
    import asteroids::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_done = 1'b0, wave_start = 1'b0, hit_valid = 1'b0;
    logic [2:0] hit_idx = '0;
    logic hit_ready;
    logic [N-1:0][9:0] ast_x = '0;
    logic [N-1:0][8:0] ast_y = '0;
    logic [N-1:0] new_asteroid, asteroid_hit, active;
    ast_t [N-1:0] ast_type;
    logic [9:0] x_init;
    logic [8:0] y_init;
    logic [9:0] phase_n;
    logic [3:0] phase_inc_n;
    logic score_valid;
    logic [6:0] score_pts;
    logic wave_clear;
    logic [3:0] wave_num;

    int vectors = 0;
    int miscompares = 0;
    int clear_cnt = 0;
    logic [15:0] m_lfsr, m_prev;

    asteroid_spawner #(
        .N_AST(8), .WIDTH(640), .HEIGHT(480), .WAVE_BASE(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start_done(start_done), .wave_start(wave_start),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_ready(hit_ready),
        .ast_x(ast_x), .ast_y(ast_y), .new_asteroid(new_asteroid),
        .asteroid_hit(asteroid_hit), .ast_type(ast_type), .x_init(x_init),
        .y_init(y_init), .phase_n(phase_n), .phase_inc_n(phase_inc_n),
        .active(active), .score_valid(score_valid), .score_pts(score_pts),
        .wave_clear(wave_clear), .wave_num(wave_num)
    );

    always #5 clk = ~clk;

    // Reference LFSR: m_prev is the value the DUT used during the previous cycle.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        m_prev <= m_lfsr;
    end

    always @(negedge clk) begin
        if (!reset && wave_clear) clear_cnt <= clear_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hit_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL hit_ready_timeout: got %b want 1 within 20 cycles", hit_ready);
        end
    endtask

    task automatic pulse_hit(input int idx);
        hit_idx   = 3'(idx);
        hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic test_reset();
        ast_t [N-1:0] exp_t;
        for (int i = 0; i < N; i++) exp_t[i] = AST_LARGE;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({new_asteroid, asteroid_hit, active, score_valid, score_pts, wave_clear,
             wave_num, hit_ready, x_init, y_init, phase_n, phase_inc_n} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got new=%h hit=%h act=%h sv=%b pts=%0d wc=%b wn=%0d rdy=%b x=%0d y=%0d ph=%0d inc=%0d want all 0",
                     new_asteroid, asteroid_hit, active, score_valid, score_pts, wave_clear,
                     wave_num, hit_ready, x_init, y_init, phase_n, phase_inc_n);
        end
        vectors++;
        if (ast_type !== exp_t) begin
            miscompares++;
            $display("FAIL reset_types: got %h want %h", ast_type, exp_t);
        end
        reset = 1'b0;
    endtask

    task automatic test_wave(input int count, input logic sd);
        int ex, ey;
        logic [N-1:0] exp_act;
        start_done = sd;
        wave_start = 1'b1;
        tick();
        wave_start = 1'b0;
        for (int i = 0; i < count; i++) begin
            if (!m_prev[15]) begin
                ex = 0;
                ey = int'(m_prev[8:0]);
                if (ey >= 480) ey = ey - 480;
            end else begin
                ey = 0;
                ex = int'(m_prev[9:0]);
                if (ex >= 640) ex = ex - 640;
            end
            vectors++;
            if (new_asteroid !== 8'(1 << i)) begin
                miscompares++;
                $display("FAIL wave_strobe[%0d]: got %b want %b", i, new_asteroid, 8'(1 << i));
            end
            vectors++;
            if (ast_type[i] !== AST_LARGE) begin
                miscompares++;
                $display("FAIL wave_type[%0d]: got %0d want %0d", i, ast_type[i], AST_LARGE);
            end
            vectors++;
            if (int'(x_init) != ex || int'(y_init) != ey || x_init >= 10'd640 || y_init >= 9'd480) begin
                miscompares++;
                $display("FAIL wave_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", i, x_init, y_init, ex, ey);
            end
            vectors++;
            if (phase_n !== m_prev[9:0] || phase_inc_n !== m_prev[13:10]) begin
                miscompares++;
                $display("FAIL wave_phase[%0d]: got %0d/%0d want %0d/%0d", i, phase_n, phase_inc_n,
                         m_prev[9:0], m_prev[13:10]);
            end
            tick();
        end
        exp_act = 8'((1 << count) - 1);
        vectors++;
        if (new_asteroid !== '0 || active !== exp_act) begin
            miscompares++;
            $display("FAIL wave_end: got new=%b act=%b want new=0 act=%b", new_asteroid, active, exp_act);
        end
    endtask

    task automatic test_split_large();
        bit ok;
        logic [9:0] p;
        ast_x[2] = 10'd100;
        ast_y[2] = 9'd200;
        wait_ready(ok);
        pulse_hit(2);
        vectors++;
        if (asteroid_hit !== 8'h04 || score_valid !== 1'b1 || score_pts !== 7'd20) begin
            miscompares++;
            $display("FAIL large_hit: got hit=%b sv=%b pts=%0d want hit=00000100 sv=1 pts=20",
                     asteroid_hit, score_valid, score_pts);
        end
        vectors++;
        if (new_asteroid !== '0 || active !== 8'h0B) begin
            miscompares++;
            $display("FAIL large_clear: got new=%b act=%b want new=0 act=00001011", new_asteroid, active);
        end
        tick();
        vectors++;
        if (new_asteroid !== 8'h04 || ast_type[2] !== AST_MED || x_init !== 10'd100 || y_init !== 9'd200) begin
            miscompares++;
            $display("FAIL child_a: got new=%b type=%0d pos=(%0d,%0d) want new=00000100 type=1 pos=(100,200)",
                     new_asteroid, ast_type[2], x_init, y_init);
        end
        vectors++;
        if (phase_n !== m_prev[9:0] || hit_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL child_a_phase: got ph=%0d rdy=%b want ph=%0d rdy=0", phase_n, hit_ready, m_prev[9:0]);
        end
        p = m_prev[9:0];
        tick();
        vectors++;
        if (new_asteroid !== 8'h10 || ast_type[4] !== AST_MED || x_init !== 10'd100 || y_init !== 9'd200) begin
            miscompares++;
            $display("FAIL child_b: got new=%b type=%0d pos=(%0d,%0d) want new=00010000 type=1 pos=(100,200)",
                     new_asteroid, ast_type[4], x_init, y_init);
        end
        vectors++;
        if (int'(phase_n) != (int'(p) + 512) % 1024 || hit_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL child_b_phase: got ph=%0d rdy=%b want ph=%0d rdy=0", phase_n, hit_ready,
                     (int'(p) + 512) % 1024);
        end
        tick();
        vectors++;
        if (hit_ready !== 1'b1 || active !== 8'h1F || new_asteroid !== '0) begin
            miscompares++;
            $display("FAIL large_done: got rdy=%b act=%b new=%b want rdy=1 act=00011111 new=0",
                     hit_ready, active, new_asteroid);
        end
    endtask

    task automatic test_small();
        bit ok;
        ast_x[4] = 10'd300;
        ast_y[4] = 9'd50;
        wait_ready(ok);
        pulse_hit(4);
        vectors++;
        if (asteroid_hit !== 8'h10 || score_pts !== 7'd50) begin
            miscompares++;
            $display("FAIL med_hit: got hit=%b pts=%0d want hit=00010000 pts=50", asteroid_hit, score_pts);
        end
        tick();
        tick();
        vectors++;
        if (new_asteroid !== 8'h20 || ast_type[4] !== AST_SMALL || ast_type[5] !== AST_SMALL
            || x_init !== 10'd300 || y_init !== 9'd50) begin
            miscompares++;
            $display("FAIL med_children: got new=%b t4=%0d t5=%0d pos=(%0d,%0d) want new=00100000 t4=2 t5=2 pos=(300,50)",
                     new_asteroid, ast_type[4], ast_type[5], x_init, y_init);
        end
        wait_ready(ok);
        pulse_hit(5);
        vectors++;
        if (asteroid_hit !== 8'h20 || score_valid !== 1'b1 || score_pts !== 7'd100 || hit_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL small_hit: got hit=%b sv=%b pts=%0d rdy=%b want hit=00100000 sv=1 pts=100 rdy=0",
                     asteroid_hit, score_valid, score_pts, hit_ready);
        end
        tick();
        vectors++;
        if (hit_ready !== 1'b1 || new_asteroid !== '0 || active !== 8'h1F) begin
            miscompares++;
            $display("FAIL small_after: got rdy=%b new=%b act=%b want rdy=1 new=0 act=00011111",
                     hit_ready, new_asteroid, active);
        end
        tick();
        vectors++;
        if (new_asteroid !== '0) begin
            miscompares++;
            $display("FAIL small_nospawn: got new=%b want 0", new_asteroid);
        end
    endtask

    task automatic test_full_drop();
        bit ok;
        int slots [3] = '{0, 1, 3};
        foreach (slots[k]) begin
            wait_ready(ok);
            pulse_hit(slots[k]);
            vectors++;
            if (score_pts !== 7'd20 || asteroid_hit !== 8'(1 << slots[k])) begin
                miscompares++;
                $display("FAIL fill_hit[%0d]: got hit=%b pts=%0d want pts=20", slots[k], asteroid_hit, score_pts);
            end
            tick();
            tick();
            tick();
        end
        vectors++;
        if (active !== 8'hFF) begin
            miscompares++;
            $display("FAIL fill_active: got %b want 11111111", active);
        end
        wait_ready(ok);
        pulse_hit(2);
        tick();
        vectors++;
        if (new_asteroid !== 8'h04 || ast_type[2] !== AST_SMALL) begin
            miscompares++;
            $display("FAIL full_child_a: got new=%b type=%0d want new=00000100 type=2", new_asteroid, ast_type[2]);
        end
        tick();
        vectors++;
        if (new_asteroid !== '0 || hit_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_child_b_dropped: got new=%b rdy=%b want new=0 rdy=0", new_asteroid, hit_ready);
        end
        tick();
        vectors++;
        if (hit_ready !== 1'b1 || active !== 8'hFF) begin
            miscompares++;
            $display("FAIL full_back_to_run: got rdy=%b act=%b want rdy=1 act=11111111", hit_ready, active);
        end
    endtask

    task automatic test_clear();
        bit ok;
        int pick;
        for (int it = 0; it < 100 && active !== '0; it++) begin
            wait_ready(ok);
            if (!ok) break;
            pick = 0;
            for (int i = N - 1; i >= 0; i--) if (active[i]) pick = i;
            pulse_hit(pick);
            tick();
            tick();
        end
        tick();
        tick();
        vectors++;
        if (clear_cnt !== 1 || wave_num !== 4'd1) begin
            miscompares++;
            $display("FAIL wave_clear: got pulses=%0d wave_num=%0d want pulses=1 wave_num=1", clear_cnt, wave_num);
        end
        vectors++;
        if (hit_ready !== 1'b0 || active !== '0 || wave_clear !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_idle: got rdy=%b act=%b wc=%b want rdy=0 act=0 wc=0", hit_ready, active, wave_clear);
        end
    endtask

    task automatic test_inactive_hit();
        bit ok;
        wait_ready(ok);
        hit_idx    = 3'd7;
        hit_valid  = 1'b1;
        wave_start = 1'b1;
        tick();
        hit_valid  = 1'b0;
        wave_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (asteroid_hit !== '0 || new_asteroid !== '0 || score_valid !== 1'b0
                || active !== 8'h3F || hit_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL inactive_hit[%0d]: got hit=%b new=%b sv=%b act=%b rdy=%b want 0/0/0/00111111/1",
                         i, asteroid_hit, new_asteroid, score_valid, active, hit_ready);
            end
            tick();
        end
    endtask

    task automatic test_reset_split();
        bit ok;
        wait_ready(ok);
        pulse_hit(0);
        reset = 1'b1;
        tick();
        vectors++;
        if ({new_asteroid, asteroid_hit, active, score_valid, wave_clear, wave_num, hit_ready} !== '0) begin
            miscompares++;
            $display("FAIL split_reset: got new=%b hit=%b act=%b sv=%b wc=%b wn=%0d rdy=%b want all 0",
                     new_asteroid, asteroid_hit, active, score_valid, wave_clear, wave_num, hit_ready);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (new_asteroid !== '0 || asteroid_hit !== '0 || active !== '0 || hit_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset[%0d]: got new=%b hit=%b act=%b rdy=%b want all 0",
                         i, new_asteroid, asteroid_hit, active, hit_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wave(4, 1'b1);
        test_split_large();
        test_small();
        test_full_drop();
        test_clear();
        test_wave(6, 1'b0);
        test_inactive_hit();
        test_reset_split();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
